// File: rtl/rx_matrix_loader_if.sv
// Byte-stream in, matrix-pair out: groups the UART side and the systolic-array side of the loader.
// master drives bytes and mat_ready; slave is the loader.
interface rx_matrix_loader_if #(
   parameter int N = 4
);
   logic [7:0]       rx_data;
   logic             rx_valid;
   logic             mat_ready;
   logic             mat_valid;
   logic [N*N*8-1:0] a_flat;
   logic [N*N*8-1:0] b_flat;
   logic             busy;
   logic             err;
   logic             ovf;

   modport master (
      output rx_data, rx_valid, mat_ready,
      input  mat_valid, a_flat, b_flat, busy, err, ovf
   );

   modport slave (
      input  rx_data, rx_valid, mat_ready,
      output mat_valid, a_flat, b_flat, busy, err, ovf
   );
endinterface

// File: rtl/rx_matrix_loader.sv
// Assembles a checksummed SYNC-framed byte stream into two N x N 8-bit matrices
// and holds them for a valid/ready handshake to the systolic array.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | hunting for SYNC; non-SYNC bytes ignored
//   LOAD_A  | filling shadow A row-major, XOR accumulating
//   LOAD_B  | filling shadow B row-major, XOR accumulating
//   CHECK   | waiting for checksum byte; match publishes shadows
//   HOLD    | mat_valid high until handshake; incoming bytes dropped (ovf)
module rx_matrix_loader #(
   parameter int         N       = 4,
   parameter logic [7:0] SYNC    = 8'hA5,
   parameter int         TIMEOUT = 100000
) (
   input  logic               clk,
   input  logic               rst,
   rx_matrix_loader_if.slave  bus
);

   localparam int ELEMS = N * N;
   localparam int W     = ELEMS * 8;
   localparam int IDX_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ELEMS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_A,
      ST_LOAD_B,
      ST_CHECK,
      ST_HOLD
   } state_e;

   state_e           state_q,    state_d;
   logic [IDX_W-1:0] idx_q,      idx_d;
   logic [7:0]       xor_q,      xor_d;
   logic [CNT_W-1:0] gap_q,      gap_d;
   logic [W-1:0]     shadow_a_q, shadow_a_d;
   logic [W-1:0]     shadow_b_q, shadow_b_d;
   logic [W-1:0]     a_flat_q,   a_flat_d;
   logic [W-1:0]     b_flat_q,   b_flat_d;
   logic             err_q,      err_d;
   logic             ovf_q,      ovf_d;

   logic [CNT_W-1:0] gap_inc;
   logic             gap_hit;

   function automatic logic [W-1:0] put_byte(
      input logic [W-1:0]     vec,
      input logic [IDX_W-1:0] idx,
      input logic [7:0]       data
   );
      logic [W-1:0] r;
      r = vec;
      for (int k = 0; k < ELEMS; k++) begin
         if (idx == IDX_W'(k)) begin
            r[k*8 +: 8] = data;
         end
      end
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         xor_q      <= '0;
         gap_q      <= '0;
         shadow_a_q <= '0;
         shadow_b_q <= '0;
         a_flat_q   <= '0;
         b_flat_q   <= '0;
         err_q      <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         xor_q      <= xor_d;
         gap_q      <= gap_d;
         shadow_a_q <= shadow_a_d;
         shadow_b_q <= shadow_b_d;
         a_flat_q   <= a_flat_d;
         b_flat_q   <= b_flat_d;
         err_q      <= err_d;
         ovf_q      <= ovf_d;
      end
   end

   // A byte in the same cycle the gap would hit TIMEOUT wins over the timeout.
   assign gap_inc = gap_q + CNT_W'(1);
   assign gap_hit = (gap_inc == CNT_MAX);

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      xor_d      = xor_q;
      gap_d      = gap_q;
      shadow_a_d = shadow_a_q;
      shadow_b_d = shadow_b_q;
      a_flat_d   = a_flat_q;
      b_flat_d   = b_flat_q;
      err_d      = 1'b0;
      ovf_d      = ovf_q;

      case (state_q)
         ST_IDLE: begin
            gap_d = '0;
            if (bus.rx_valid && (bus.rx_data == SYNC)) begin
               state_d = ST_LOAD_A;
               idx_d   = '0;
               xor_d   = '0;
            end
         end

         ST_LOAD_A: begin
            if (bus.rx_valid) begin
               shadow_a_d = put_byte(shadow_a_q, idx_q, bus.rx_data);
               xor_d      = xor_q ^ bus.rx_data;
               gap_d      = '0;
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = ST_LOAD_B;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else if (gap_hit) begin
               err_d   = 1'b1;
               gap_d   = '0;
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_inc;
            end
         end

         ST_LOAD_B: begin
            if (bus.rx_valid) begin
               shadow_b_d = put_byte(shadow_b_q, idx_q, bus.rx_data);
               xor_d      = xor_q ^ bus.rx_data;
               gap_d      = '0;
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = ST_CHECK;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else if (gap_hit) begin
               err_d   = 1'b1;
               gap_d   = '0;
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_inc;
            end
         end

         ST_CHECK: begin
            if (bus.rx_valid) begin
               gap_d = '0;
               if (bus.rx_data == xor_q) begin
                  a_flat_d = shadow_a_q;
                  b_flat_d = shadow_b_q;
                  state_d  = ST_HOLD;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end else if (gap_hit) begin
               err_d   = 1'b1;
               gap_d   = '0;
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_inc;
            end
         end

         ST_HOLD: begin
            gap_d = '0;
            // Dropped bytes never reach SYNC detection, even in the handshake cycle.
            if (bus.rx_valid) begin
               ovf_d = 1'b1;
            end
            if (bus.mat_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.mat_valid = (state_q == ST_HOLD);
   assign bus.busy      = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B) ||
                          (state_q == ST_CHECK);
   assign bus.a_flat    = a_flat_q;
   assign bus.b_flat    = b_flat_q;
   assign bus.err       = err_q;
   assign bus.ovf       = ovf_q;

endmodule
